// File: rtl/riscv_iq_pkg.sv
// Shared types for the RISC-V issue queue: default entry layout, load FSM states
// and the default load opcode.
package riscv_iq_pkg;

    localparam int IQ_REG_WIDTH   = 5;
    localparam int IQ_OP_WIDTH    = 7;
    localparam int IQ_DATA_WIDTH  = 10;
    localparam int IQ_LOAD_OPCODE = 0;

    // Entry layout at the default geometry; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic [IQ_REG_WIDTH-1:0]  rs0;
        logic [IQ_REG_WIDTH-1:0]  rs1;
        logic [IQ_REG_WIDTH-1:0]  rd;
        logic [IQ_OP_WIDTH-1:0]   opcode;
        logic [IQ_DATA_WIDTH-1:0] data;
        logic                     done;
        logic                     err;
    } iq_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } iq_state_e;

endpackage

// File: rtl/riscv_iq_fifo.sv
// Generic circular buffer of entry_t with a write port into the current head entry.
// Depth need not be a power of two.
module riscv_iq_fifo
    import riscv_iq_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = iq_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       head_wr,
    input  entry_t                     head_wr_data,
    output entry_t                     head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign push_s  = push && !full_s;
    assign pop_s   = pop && !empty_s;

    // Storage, pointers and occupancy; the head write never targets the push slot
    // because it only happens while the queue is neither empty nor accepting into that slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (head_wr && !empty_s) begin
                mem_r[rd_ptr_r] <= head_wr_data;
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;

endmodule

// File: rtl/riscv_issue_queue.sv
// Issue queue: FIFO of decoded instructions with in-order load tracking at the head.
// Optional load watchdog enabled by defining RISCV_IQ_LD_TIMEOUT_EN.
module riscv_issue_queue
    import riscv_iq_pkg::*;
#(
    parameter int REG_WIDTH      = 5,
    parameter int OP_WIDTH       = 7,
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 10,
    parameter int LOAD_OPCODE    = IQ_LOAD_OPCODE,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [REG_WIDTH-1:0]            rs0,
    input  logic [REG_WIDTH-1:0]            rs1,
    input  logic [REG_WIDTH-1:0]            rd,
    input  logic [OP_WIDTH-1:0]             opcode,
    output logic                            ld_req,
    output logic [ADDR_WIDTH-1:0]           ld_addr,
    input  logic [DATA_WIDTH-1:0]           ld_data,
    input  logic                            ld_data_valid,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [REG_WIDTH-1:0]            rs0_out,
    output logic [REG_WIDTH-1:0]            rs1_out,
    output logic [REG_WIDTH-1:0]            rd_out,
    output logic [OP_WIDTH-1:0]             opcode_out,
    output logic [DATA_WIDTH-1:0]           ld_data_out,
    output logic                            err_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [REG_WIDTH-1:0]  rs0;
        logic [REG_WIDTH-1:0]  rs1;
        logic [REG_WIDTH-1:0]  rd;
        logic [OP_WIDTH-1:0]   opcode;
        logic [DATA_WIDTH-1:0] data;
        logic                  done;
        logic                  err;
    } entry_t;

    entry_t                push_entry_s;
    entry_t                head_s;
    entry_t                head_upd_s;
    iq_state_e             state_r;
    iq_state_e             state_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_cnt_r;
    logic [CNT_W-1:0]      count_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  head_wr_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  head_is_load_s;
    logic                  in_is_load_s;
    logic                  tmo_hit_s;

    assign push_entry_s = '{rs0: rs0, rs1: rs1, rd: rd, opcode: opcode,
                            data: {DATA_WIDTH{1'b0}}, done: 1'b0, err: 1'b0};

    assign head_is_load_s = (head_s.opcode == OP_WIDTH'(LOAD_OPCODE));
    assign in_is_load_s   = (opcode == OP_WIDTH'(LOAD_OPCODE));
    assign in_ready       = !full_s;
    assign push_s         = in_valid && !full_s;
    assign out_valid      = !empty_s && (!head_is_load_s || head_s.done);
    assign pop_s          = out_valid && out_ready;

    riscv_iq_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push_s),
        .push_data    (push_entry_s),
        .pop          (pop_s),
        .head_wr      (head_wr_s),
        .head_wr_data (head_upd_s),
        .head_data    (head_s),
        .count        (count_s),
        .full         (full_s),
        .empty        (empty_s)
    );

`ifdef RISCV_IQ_LD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    assign tmo_hit_s = (state_r == WAIT) && !ld_data_valid &&
                       (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles spent in WAIT, cleared whenever the FSM leaves it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    assign err_out = !empty_s && head_s.err;
`else
    logic tmo_unused_s;

    assign tmo_hit_s    = 1'b0;
    assign tmo_unused_s = ^{head_s.err, TIMEOUT_CYCLES[0]};
    assign err_out      = 1'b0;
`endif

    // Load FSM state register and load address counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            addr_cnt_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == REQ) begin
                addr_cnt_r <= addr_cnt_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Next state and head update; a load pushed into an empty queue is seen at the push edge.
    always_comb begin
        state_nxt_s = state_r;
        head_wr_s   = 1'b0;
        head_upd_s  = head_s;
        case (state_r)
            IDLE: begin
                if ((!empty_s && head_is_load_s && !head_s.done) ||
                    (empty_s && push_s && in_is_load_s)) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (ld_data_valid) begin
                    head_wr_s       = 1'b1;
                    head_upd_s.data = ld_data;
                    head_upd_s.done = 1'b1;
                    head_upd_s.err  = 1'b0;
                    state_nxt_s     = IDLE;
                end else if (tmo_hit_s) begin
                    head_wr_s       = 1'b1;
                    head_upd_s.data = {DATA_WIDTH{1'b1}};
                    head_upd_s.done = 1'b1;
                    head_upd_s.err  = 1'b1;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign ld_req      = (state_r == REQ);
    assign ld_addr     = addr_cnt_r;
    assign rs0_out     = head_s.rs0;
    assign rs1_out     = head_s.rs1;
    assign rd_out      = head_s.rd;
    assign opcode_out  = head_s.opcode;
    assign ld_data_out = head_s.data;
    assign count       = count_s;

endmodule
